// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the sample-SRAM voice arbiter:
//   - state_t    : arbiter FSM state encoding
//   - DEF_*      : default parameter values used by sram_voice_arbiter
//   - DEF_ACC_W  : mix accumulator width (DATA_W + 2 headroom bits)
// ---------------------------------------------------------------------------
package synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_READ   = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_DATA_W     = 16;
    // Two headroom bits hold the sum of four full-scale signed samples.
    localparam int DEF_ACC_W      = DEF_DATA_W + 2;

endpackage

// File: rtl/mix_saturate.sv
// ---------------------------------------------------------------------------
// mix_saturate
// Combinational conversion of the mix accumulator to an output sample.
// Build option: MIX_SATURATE_EN
//   defined   : accumulator clamped to the signed DATA_W range
//   undefined : accumulator arithmetic-shifted right by 2 (divide by 4)
// Ports:
//   i_acc  in  ACC_W   signed accumulator value
//   o_data out DATA_W  signed output sample
// ---------------------------------------------------------------------------
module mix_saturate #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = DATA_W + 2
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic        [DATA_W-1:0] o_data
);

`ifdef MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp the full sum into the representable output range.
    always_comb begin
        if (i_acc > SAT_MAX) begin
            o_data = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (i_acc < SAT_MIN) begin
            o_data = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            o_data = i_acc[DATA_W-1:0];
        end
    end
`else
    // Dropped fraction bits of the divide-by-4; kept only to mark them consumed.
    logic w_unused_lsb;

    // Arithmetic shift by 2: with ACC_W = DATA_W + 2 the top slice is exact.
    always_comb begin
        o_data       = i_acc[DATA_W+1:2];
        w_unused_lsb = ^i_acc[1:0];
    end
`endif

endmodule

// File: rtl/sram_voice_arbiter.sv
// ---------------------------------------------------------------------------
// sram_voice_arbiter
// Shares one asynchronous sample SRAM between NUM_VOICES voice requesters.
// On each sample_tick the active voices are snapshotted, read one at a time in
// ascending index order, summed into a signed accumulator and converted to one
// output sample by mix_saturate (build option MIX_SATURATE_EN selects clamp vs
// divide-by-4).
// Ports:
//   Clk, Reset               clock, async active-high reset
//   sample_tick              one-cycle frame start pulse
//   voice_req / voice_addr   per-voice request and word address
//   voice_ack                one-cycle pulse when a voice's word is consumed
//   SRAM_ADDR/CE_N/OE_N/DQ   SRAM read interface
//   audio_data / audio_valid mixed sample and its update strobe
//   overrun                  sticky: tick arrived while a frame was running
// ---------------------------------------------------------------------------
module sram_voice_arbiter
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SRAM_WAIT  = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES-1:0]        voice_req,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_addr,
    output logic [NUM_VOICES-1:0]        voice_ack,
    output logic [ADDR_W-1:0]            SRAM_ADDR,
    output logic                         SRAM_CE_N,
    output logic                         SRAM_OE_N,
    input  logic [DATA_W-1:0]            SRAM_DQ,
    output logic [DATA_W-1:0]            audio_data,
    output logic                         audio_valid,
    output logic                         overrun
);

    localparam int         ACC_W     = DATA_W + 2;
    localparam int         IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_VOICES-1:0]     r_snap;
    logic [NUM_VOICES-1:0]     w_pending;
    logic [IDX_W-1:0]          r_sel;
    logic [IDX_W-1:0]          w_sel_nxt;
    logic [IDX_W-1:0]          w_first_idx;
    logic                      w_any;
    logic [2:0]                r_wait;
    logic [DATA_W-1:0]         r_word;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]         w_mix;
    logic                      w_tick_idle;
    logic                      w_last_read;

    logic [ADDR_W-1:0]         r_addr;
    logic                      r_ce_n;
    logic                      r_oe_n;
    logic [NUM_VOICES-1:0]     r_ack;
    logic [DATA_W-1:0]         r_data;
    logic                      r_valid;
    logic                      r_overrun;

    assign w_tick_idle = sample_tick && (r_state == ST_IDLE);
    assign w_last_read = (r_state == ST_READ) && (r_wait == WAIT_LAST);

    // Voices still to be served: fresh request mask at frame start, the
    // snapshot minus the voice just accumulated when leaving ACCUM.
    always_comb begin
        w_pending = r_snap;
        if (r_state == ST_IDLE) begin
            w_pending = voice_req;
        end else if (r_state == ST_ACCUM) begin
            w_pending[r_sel] = 1'b0;
        end else begin
            w_pending = r_snap;
        end
    end

    // Lowest-index pending voice; unset bits cost no cycles.
    always_comb begin
        w_any       = 1'b0;
        w_first_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            w_first_idx = w_pending[i] ? IDX_W'(i) : w_first_idx;
            w_any       = w_any | w_pending[i];
        end
    end

    // Next-state and next-voice selection.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (sample_tick) begin
                    w_state_nxt = w_any ? ST_SETUP : ST_OUTPUT;
                    w_sel_nxt   = w_first_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP:  w_state_nxt = ST_READ;
            ST_READ:   w_state_nxt = (r_wait == WAIT_LAST) ? ST_ACCUM : ST_READ;
            ST_ACCUM: begin
                w_state_nxt = w_any ? ST_SETUP : ST_OUTPUT;
                w_sel_nxt   = w_first_idx;
            end
            ST_OUTPUT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, voice pointer, snapshot, wait counter and accumulator.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_snap  <= '0;
            r_wait  <= 3'd0;
            r_word  <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            if (w_tick_idle || (r_state == ST_ACCUM)) begin
                r_snap <= w_pending;
            end
            r_wait <= (r_state == ST_READ) ? (r_wait + 3'd1) : 3'd0;
            if (w_last_read) begin
                r_word <= SRAM_DQ;
            end
            if (w_tick_idle) begin
                r_acc <= '0;
            end else if (r_state == ST_ACCUM) begin
                r_acc <= r_acc + {{(ACC_W-DATA_W){r_word[DATA_W-1]}}, r_word};
            end
        end
    end

    mix_saturate #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mix (
        .i_acc  (r_acc),
        .o_data (w_mix)
    );

    // Registered outputs, decoded from the state being entered so that the
    // SRAM strobes and ack line up with the SETUP/READ/ACCUM cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr    <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_ack     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ce_n <= !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_READ));
            r_oe_n <= !(w_state_nxt == ST_READ);
            if (w_state_nxt == ST_SETUP) begin
                r_addr <= voice_addr[w_sel_nxt*ADDR_W +: ADDR_W];
            end
            r_ack   <= (w_state_nxt == ST_ACCUM) ? (NUM_VOICES'(1) << r_sel) : '0;
            r_valid <= (r_state == ST_OUTPUT);
            if (r_state == ST_OUTPUT) begin
                r_data <= w_mix;
            end
            if (sample_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign SRAM_ADDR   = r_addr;
    assign SRAM_CE_N   = r_ce_n;
    assign SRAM_OE_N   = r_oe_n;
    assign voice_ack   = r_ack;
    assign audio_data  = r_data;
    assign audio_valid = r_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_sram_voice_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_voice_arbiter
// Directed bench for sram_voice_arbiter with default parameters
// (4 voices, 20-bit address, 16-bit data, SRAM_WAIT = 2). Expected mix
// results follow MIX_SATURATE_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_sram_voice_arbiter;

    localparam int NV = 4;
    localparam int AW = 20;
    localparam int DW = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              sample_tick;
    logic [NV-1:0]     voice_req;
    logic [NV*AW-1:0]  voice_addr;
    logic [NV-1:0]     voice_ack;
    logic [AW-1:0]     SRAM_ADDR;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic [DW-1:0]     SRAM_DQ;
    logic [DW-1:0]     audio_data;
    logic              audio_valid;
    logic              overrun;

    logic [DW-1:0]     mem_val [NV];

    int                n_checks = 0;
    int                n_pass   = 0;

    int                valid_cyc;
    int                valid_cnt;
    logic [DW-1:0]     got_data;
    logic              saw_ce;
    logic [AW-1:0]     setup_addr [$];
    logic [NV-1:0]     ack_val [$];
    int                ack_cyc [$];

    always #10 Clk = ~Clk;

    sram_voice_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sample_tick (sample_tick),
        .voice_req   (voice_req),
        .voice_addr  (voice_addr),
        .voice_ack   (voice_ack),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_DQ     (SRAM_DQ),
        .audio_data  (audio_data),
        .audio_valid (audio_valid),
        .overrun     (overrun)
    );

    // SRAM model: drives the word of the voice whose address is presented,
    // and a marker value whenever the device is not being read.
    always_comb begin
        SRAM_DQ = 16'hDEAD;
        if (!SRAM_CE_N && !SRAM_OE_N) begin
            for (int i = 0; i < NV; i++) begin
                if (SRAM_ADDR == voice_addr[i*AW +: AW]) SRAM_DQ = mem_val[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs a frame whose tick was raised by the caller; cycle n is the n-th
    // cycle after the tick cycle. Optionally re-ticks at cycle second_at and
    // changes voice_req right after the tick.
    task automatic run_frame(input int budget, input int second_at, input logic [NV-1:0] req_after);
        valid_cyc = -1;
        valid_cnt = 0;
        got_data  = '0;
        saw_ce    = 1'b0;
        setup_addr.delete();
        ack_val.delete();
        ack_cyc.delete();
        for (int n = 1; n <= budget; n++) begin
            @(posedge Clk);
            #1;
            sample_tick = (n == second_at);
            if (n == 1) voice_req = req_after;
            if (!SRAM_CE_N) saw_ce = 1'b1;
            if (!SRAM_CE_N && SRAM_OE_N) setup_addr.push_back(SRAM_ADDR);
            if (voice_ack != '0) begin
                ack_val.push_back(voice_ack);
                ack_cyc.push_back(n);
            end
            if (audio_valid) begin
                valid_cnt++;
                if (valid_cyc < 0) begin
                    valid_cyc = n;
                    got_data  = audio_data;
                end
            end
        end
    endtask

    task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        voice_addr = {a3, a2, a1, a0};
    endtask

    initial begin
        Reset       = 1'b1;
        sample_tick = 1'b0;
        voice_req   = 4'b0000;
        set_addrs(20'h00100, 20'h00200, 20'h00300, 20'h00400);
        mem_val[0] = 16'h0100;
        mem_val[1] = 16'h1111;
        mem_val[2] = 16'h0200;
        mem_val[3] = 16'h2222;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
        check("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
        check("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_ack", 32'(voice_ack), 32'd0);
        check("rst_data", 32'(audio_data), 32'd0);
        check("rst_valid", 32'(audio_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Empty snapshot: valid two cycles after the tick, no SRAM activity
        sample_tick = 1'b1;
        voice_req   = 4'b0000;
        run_frame(8, 0, 4'b0000);
        check("k0_valid_cyc", 32'(valid_cyc), 32'd2);
        check("k0_valid_cnt", 32'(valid_cnt), 32'd1);
        check("k0_data", 32'(got_data), 32'h0000);
        check("k0_no_ce", 32'(saw_ce), 32'd0);

        // Voices 0 and 2; request change after the tick must be ignored
        sample_tick = 1'b1;
        voice_req   = 4'b0101;
        run_frame(20, 0, 4'b1111);
        check("k2_n_setup", 32'(setup_addr.size()), 32'd2);
        check("k2_addr0", 32'(setup_addr[0]), 32'h00100);
        check("k2_addr1", 32'(setup_addr[1]), 32'h00300);
        check("k2_n_ack", 32'(ack_val.size()), 32'd2);
        check("k2_ack0", 32'(ack_val[0]), 32'b0001);
        check("k2_ack0_cyc", 32'(ack_cyc[0]), 32'd4);
        check("k2_ack1", 32'(ack_val[1]), 32'b0100);
        check("k2_ack1_cyc", 32'(ack_cyc[1]), 32'd8);
        check("k2_valid_cyc", 32'(valid_cyc), 32'd10);
`ifdef MIX_SATURATE_EN
        check("k2_data", 32'(got_data), 32'h0300);
`else
        check("k2_data", 32'(got_data), 32'h00C0);
`endif

        // All four voices at 0x7000
        for (int i = 0; i < NV; i++) mem_val[i] = 16'h7000;
        sample_tick = 1'b1;
        voice_req   = 4'b1111;
        run_frame(24, 0, 4'b1111);
        check("k4_n_setup", 32'(setup_addr.size()), 32'd4);
        check("k4_addr3", 32'(setup_addr[3]), 32'h00400);
        check("k4_ack3", 32'(ack_val[3]), 32'b1000);
        check("k4_valid_cyc", 32'(valid_cyc), 32'd18);
`ifdef MIX_SATURATE_EN
        check("k4_data", 32'(got_data), 32'h7FFF);
`else
        check("k4_data", 32'(got_data), 32'h7000);
`endif
        check("k4_overrun", 32'(overrun), 32'd0);

        // Second tick three cycles into a four-voice frame
        sample_tick = 1'b1;
        voice_req   = 4'b1111;
        run_frame(30, 3, 4'b1111);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid_cnt", 32'(valid_cnt), 32'd1);
        check("ovr_valid_cyc", 32'(valid_cyc), 32'd18);
        check("ovr_n_setup", 32'(setup_addr.size()), 32'd4);
`ifdef MIX_SATURATE_EN
        check("ovr_data", 32'(got_data), 32'h7FFF);
`else
        check("ovr_data", 32'(got_data), 32'h7000);
`endif

        // Reset during the read of voice 1
        mem_val[0] = 16'h0040;
        mem_val[1] = 16'h0080;
        sample_tick = 1'b1;
        voice_req   = 4'b0011;
        for (int n = 1; n <= 6; n++) begin
            @(posedge Clk);
            #1;
            sample_tick = 1'b0;
        end
        check("mid_oe_low", 32'(SRAM_OE_N), 32'd0);
        check("mid_addr_v1", 32'(SRAM_ADDR), 32'h00200);
        Reset = 1'b1;
        #1;
        check("mid_rst_oe", 32'(SRAM_OE_N), 32'd1);
        check("mid_rst_ce", 32'(SRAM_CE_N), 32'd1);
        check("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        valid_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge Clk);
            #1;
            if (audio_valid) valid_cnt++;
        end
        check("mid_rst_no_valid", 32'(valid_cnt), 32'd0);

        // Tick coincident with the first edge after reset release
        Reset       = 1'b0;
        sample_tick = 1'b1;
        voice_req   = 4'b0011;
        run_frame(20, 0, 4'b0011);
        check("rst_tick_addr0", 32'(setup_addr[0]), 32'h00100);
        check("rst_tick_addr1", 32'(setup_addr[1]), 32'h00200);
        check("rst_tick_ack0", 32'(ack_val[0]), 32'b0001);
        check("rst_tick_valid_cyc", 32'(valid_cyc), 32'd10);
`ifdef MIX_SATURATE_EN
        check("rst_tick_data", 32'(got_data), 32'h00C0);
`else
        check("rst_tick_data", 32'(got_data), 32'h0030);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // At most one ack per cycle, checked on the falling edge.
    always @(negedge Clk) begin
        if (voice_ack != '0) check("ack_onehot", 32'($onehot(voice_ack)), 32'd1);
    end

endmodule
